// File: rtl/pipeline_branch_resolver_pkg.sv
// Shared pipeline definitions: redirect FSM encoding, PC width and the
// word-alignment check that fetch also uses.
`ifndef PIPELINE_BRANCH_RESOLVER_PKG_SV
`define PIPELINE_BRANCH_RESOLVER_PKG_SV

`define PBR_PC_ALIGNED(pc) ((pc[1:0]) == 2'b00)

package pipeline_branch_resolver_pkg;

  localparam int PC_WIDTH = 32;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_ISSUE_ENC  = 2'd1;
  localparam logic [1:0] ST_WAIT_ENC   = 2'd2;
  localparam logic [1:0] ST_DONE_ENC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE        = ST_IDLE_ENC,
    ST_ISSUE       = ST_ISSUE_ENC,
    ST_WAIT_ARRIVE = ST_WAIT_ENC,
    ST_DONE        = ST_DONE_ENC
  } br_state_e;

endpackage

`endif

// File: rtl/pipeline_redirect_timer.sv
// Arrival timeout and reissue counters for the late-branch redirect.
// expire fires on the last counted cycle; retries advance on each expire.
module pipeline_redirect_timer #(
  parameter int ARRIVE_TIMEOUT = 15,
  parameter int MAX_RETRY      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  input  logic retry_clear,
  output logic expire,
  output logic retry_exhausted
);

  localparam int TW = (ARRIVE_TIMEOUT > 1) ? $clog2(ARRIVE_TIMEOUT) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(ARRIVE_TIMEOUT - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  assign expire          = start && (tcnt_q == T_LAST);
  assign retry_exhausted = (rcnt_q == R_MAX);

  always_comb begin
    tcnt_d = tcnt_q;
    rcnt_d = rcnt_q;
    if (clear)
      tcnt_d = '0;
    else if (start)
      tcnt_d = expire ? '0 : tcnt_q + TW'(1);
    if (retry_clear)
      rcnt_d = '0;
    else if (expire && !retry_exhausted)
      rcnt_d = rcnt_q + RW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      rcnt_q <= rcnt_d;
    end
  end

endmodule

// File: rtl/pipeline_branch_resolver.sv
// Late-branch responder: redirects fetch to an ALU-stage branch target, flushes
// the wrong path and pulses br_late_done once the target reaches fetch output.
module pipeline_branch_resolver
  import pipeline_branch_resolver_pkg::*;
#(
  parameter int ARRIVE_TIMEOUT = 15,
  parameter int MAX_RETRY      = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                br_late_enable,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                fetch_ready,
  input  logic                fetch_pc_valid,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  output logic                redirect_valid,
  output logic [PC_WIDTH-1:0] redirect_pc,
  output logic                flush,
  output logic                br_late_done,
  output logic                busy,
  output logic                err_misaligned,
  output logic                err_timeout,
  output logic [31:0]         redirect_count
);

  br_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0] tgt_q, tgt_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                flush_q, flush_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                err_mis_q, err_mis_d;
  logic                err_to_q, err_to_d;
  logic [31:0]         count_q, count_d;

  logic tmr_start, tmr_clear, tmr_retry_clear, tmr_expire, tmr_exhausted;
  logic take_req, arrived;

  assign arrived = fetch_pc_valid && (fetch_pc == tgt_q);

  pipeline_redirect_timer #(
    .ARRIVE_TIMEOUT(ARRIVE_TIMEOUT),
    .MAX_RETRY     (MAX_RETRY)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .start          (tmr_start),
    .clear          (tmr_clear),
    .retry_clear    (tmr_retry_clear),
    .expire         (tmr_expire),
    .retry_exhausted(tmr_exhausted)
  );

  always_comb begin
    state_d         = state_q;
    tgt_d           = tgt_q;
    flush_d         = 1'b0;
    err_mis_d       = err_mis_q;
    err_to_d        = err_to_q;
    count_d         = count_q;
    tmr_start       = 1'b0;
    tmr_clear       = 1'b0;
    tmr_retry_clear = 1'b0;
    take_req        = 1'b0;

    case (state_q)
      ST_IDLE: take_req = 1'b1;
      ST_ISSUE: begin
        if (redirect_valid_q && fetch_ready) begin
          count_d   = count_q + 32'd1;
          tmr_clear = 1'b1;
          state_d   = ST_WAIT_ARRIVE;
        end
      end
      ST_WAIT_ARRIVE: begin
        // Only a match seen here counts; anything during ISSUE is stale.
        if (arrived) begin
          state_d = ST_DONE;
        end else begin
          tmr_start = 1'b1;
          if (tmr_expire) begin
            if (!tmr_exhausted) begin
              state_d = ST_ISSUE;
              flush_d = 1'b1;
            end else begin
              err_to_d = 1'b1;
              state_d  = ST_DONE;
            end
          end
        end
      end
      default: begin
        take_req = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase

    // Requests outside IDLE/DONE are protocol violations and are dropped.
    if (take_req && br_late_enable) begin
      if (`PBR_PC_ALIGNED(br_target)) begin
        tgt_d           = br_target;
        tmr_retry_clear = 1'b1;
        flush_d         = 1'b1;
        state_d         = ST_ISSUE;
      end else begin
        err_mis_d = 1'b1;
        state_d   = ST_DONE;
      end
    end

    redirect_valid_d = (state_d == ST_ISSUE);
    redirect_pc_d    = redirect_valid_d ? tgt_d : '0;
    done_d           = (state_d == ST_DONE);
    busy_d           = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      tgt_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      done_q           <= 1'b0;
      busy_q           <= 1'b0;
      err_mis_q        <= 1'b0;
      err_to_q         <= 1'b0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      tgt_q            <= tgt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      done_q           <= done_d;
      busy_q           <= busy_d;
      err_mis_q        <= err_mis_d;
      err_to_q         <= err_to_d;
      count_q          <= count_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign br_late_done   = done_q;
  assign busy           = busy_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;
  assign redirect_count = count_q;

endmodule

// File: tb/tb_pipeline_branch_resolver.sv
// Directed bench for pipeline_branch_resolver: per-cycle vector table plus
// hand-written backpressure, timeout, back-to-back and async-reset sequences.
module tb_pipeline_branch_resolver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        br_late_enable = 1'b0;
  logic [31:0] br_target = '0;
  logic        fetch_ready = 1'b0;
  logic        fetch_pc_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        br_late_done;
  logic        busy;
  logic        err_misaligned;
  logic        err_timeout;
  logic [31:0] redirect_count;

  int checks = 0;
  int errors = 0;

  pipeline_branch_resolver dut (
    .clk           (clk),
    .rst           (rst),
    .br_late_enable(br_late_enable),
    .br_target     (br_target),
    .fetch_ready   (fetch_ready),
    .fetch_pc_valid(fetch_pc_valid),
    .fetch_pc      (fetch_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
    .br_late_done  (br_late_done),
    .busy          (busy),
    .err_misaligned(err_misaligned),
    .err_timeout   (err_timeout),
    .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  // Requests while the resolver is in ISSUE or WAIT_ARRIVE are illegal.
  always @(posedge clk) begin
    if (!rst)
      assert (!(br_late_enable && busy && !br_late_done))
        else $error("protocol violation: br_late_enable while redirect in flight");
  end

  typedef struct {
    logic        en;
    logic [31:0] tgt;
    logic        frdy;
    logic        fpv;
    logic [31:0] fpc;
    logic        rv;
    logic [31:0] pc;
    logic        fl;
    logic        dn;
    logic        by;
    logic        em;
    logic        et;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rv, input logic [31:0] pc,
                         input logic fl, input logic dn, input logic by,
                         input logic em, input logic et, input logic [31:0] cnt);
    chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
    chk({tag, ".redirect_pc"}, redirect_pc, pc);
    chk({tag, ".flush"}, 32'(flush), 32'(fl));
    chk({tag, ".br_late_done"}, 32'(br_late_done), 32'(dn));
    chk({tag, ".busy"}, 32'(busy), 32'(by));
    chk({tag, ".err_misaligned"}, 32'(err_misaligned), 32'(em));
    chk({tag, ".err_timeout"}, 32'(err_timeout), 32'(et));
    chk({tag, ".redirect_count"}, redirect_count, cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // en tgt frdy fpv fpc | rv pc fl dn by em et cnt (outputs after the edge)
    tbl[0]  = '{1'b1, 32'h40,  1'b1, 1'b0, 32'h0,   1'b1, 32'h40,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1};
    tbl[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h40,  1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1};
    tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[4]  = '{1'b1, 32'h42,  1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd1};
    tbl[5]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1};
    tbl[6]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1};
    tbl[7]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1};
    tbl[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2};
    tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2};
    tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2};
    tbl[11] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd2};
    tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2};

    // reset state
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      br_late_enable = tbl[i].en;
      br_target      = tbl[i].tgt;
      fetch_ready    = tbl[i].frdy;
      fetch_pc_valid = tbl[i].fpv;
      fetch_pc       = tbl[i].fpc;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].rv, tbl[i].pc, tbl[i].fl, tbl[i].dn,
              tbl[i].by, tbl[i].em, tbl[i].et, tbl[i].cnt);
    end

    // backpressure: fetch_ready low for 5 cycles
    br_late_enable = 1'b1; br_target = 32'h40; fetch_ready = 1'b0;
    fetch_pc_valid = 1'b0; fetch_pc = 32'h0;
    tick();
    br_late_enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp%0d.redirect_valid", i), 32'(redirect_valid), 32'd1);
      chk($sformatf("bp%0d.redirect_pc", i), redirect_pc, 32'h40);
      chk($sformatf("bp%0d.flush", i), 32'(flush), (i == 0) ? 32'd1 : 32'd0);
      chk($sformatf("bp%0d.redirect_count", i), redirect_count, 32'd2);
      fetch_ready = (i == 5);
      tick();
    end
    chk("bp.after.redirect_valid", 32'(redirect_valid), 32'd0);
    chk("bp.after.redirect_count", redirect_count, 32'd3);
    fetch_pc_valid = 1'b1; fetch_pc = 32'h40;
    tick();
    chk("bp.done", 32'(br_late_done), 32'd1);
    fetch_pc_valid = 1'b0;
    tick();

    // timeout: target never arrives
    begin
      int flushes = 0;
      int issues = 0;
      int dones = 0;
      int done_at = -1;
      logic prev_rv = 1'b0;
      br_late_enable = 1'b1; br_target = 32'h200; fetch_ready = 1'b1;
      tick();
      br_late_enable = 1'b0;
      for (int c = 1; c <= 80; c++) begin
        if (flush) flushes++;
        if (redirect_valid && !prev_rv) issues++;
        prev_rv = redirect_valid;
        if (br_late_done) begin
          dones++;
          if (done_at < 0) done_at = c;
          chk("to.err_timeout_at_done", 32'(err_timeout), 32'd1);
        end
        tick();
      end
      chk("to.flush_pulses", 32'(flushes), 32'd4);
      chk("to.issue_entries", 32'(issues), 32'd4);
      chk("to.done_pulses", 32'(dones), 32'd1);
      chk("to.done_cycle", 32'(done_at), 32'd65);
      chk("to.redirect_count", redirect_count, 32'd7);
      chk("to.busy_after", 32'(busy), 32'd0);
    end

    // back-to-back: new request during DONE
    br_late_enable = 1'b1; br_target = 32'h40; fetch_ready = 1'b1;
    tick();
    br_late_enable = 1'b0;
    tick();
    fetch_pc_valid = 1'b1; fetch_pc = 32'h40;
    tick();
    chk("b2b.done1", 32'(br_late_done), 32'd1);
    fetch_pc_valid = 1'b0;
    br_late_enable = 1'b1; br_target = 32'h80;
    tick();
    br_late_enable = 1'b0;
    chk_out("b2b.reissue", 1'b1, 32'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd8);
    tick();
    fetch_pc_valid = 1'b1; fetch_pc = 32'h80;
    tick();
    chk("b2b.done2", 32'(br_late_done), 32'd1);
    chk("b2b.count", redirect_count, 32'd9);
    fetch_pc_valid = 1'b0;
    tick();

    // asynchronous reset while in WAIT_ARRIVE
    br_late_enable = 1'b1; br_target = 32'h40; fetch_ready = 1'b1;
    tick();
    br_late_enable = 1'b0;
    tick();
    chk("rstw.in_wait_count", redirect_count, 32'd10);
    #2 rst = 1'b1;
    #1;
    chk_out("rstw.immediate", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    fetch_pc_valid = 1'b1; fetch_pc = 32'h40;
    tick();
    chk("rstw.no_done_in_reset", 32'(br_late_done), 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk_out("rstw.released", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    fetch_pc_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
